// File: rtl/flush_sequencer_if.sv
// Request/flush handshake bundle between the CSR/commit side and the flush sequencer.
// The master drives requests and acks; the slave (the sequencer) drives ready and the flush vector.
interface flush_sequencer_if #(
  parameter int NUM_CH = 16
);
  logic              req_valid;
  logic [NUM_CH-1:0] req;
  logic              req_ready;
  logic [NUM_CH-1:0] flush;
  logic [NUM_CH-1:0] flush_ack;

  modport master (output req_valid, req, flush_ack, input req_ready, flush);
  modport slave  (input req_valid, req, flush_ack, output req_ready, flush);
endinterface

// File: rtl/flush_sequencer.sv
// fence.t flush sequencer: issues a flush vector, waits for acks on handshake channels
// (bounded by a timeout), then holds completion until the timer-irq pad counter expires.
module flush_sequencer #(
  parameter int                NUM_CH      = 16,
  parameter logic [NUM_CH-1:0] ACK_MASK    = 'h0010,
  parameter int                PAD_W       = 32,
  parameter int                TIMEOUT_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  flush_sequencer_if.slave   bus,
  output logic               set_pc_commit_o,
  output logic               halt_o,
  input  logic [PAD_W-1:0]   pad_i,
  input  logic               time_irq_i,
  output logic               done_o,
  output logic               timeout_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_PAD   = 2'd3;

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [1:0]        state_q, state_d;
  logic [NUM_CH-1:0] req_q, req_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              timeout_q, timeout_d;
  logic [PAD_W-1:0]  pad_cnt_q, pad_cnt_d;
  logic              time_irq_q;
  logic              accept;
  logic              irq_rise;

  assign accept   = bus.req_valid && (state_q == S_IDLE) && (|bus.req);
  assign irq_rise = time_irq_i && !time_irq_q;

  // Pad counter is free-running beside the FSM; a fresh irq edge reloads it.
  always_comb begin
    pad_cnt_d = pad_cnt_q;
    if (irq_rise) begin
      pad_cnt_d = pad_i;
    end else if (pad_cnt_q != '0) begin
      pad_cnt_d = pad_cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    pend_d    = pend_q;
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          req_d     = bus.req;
          timeout_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pend_d    = req_q & ACK_MASK;
        tmo_cnt_d = '0;
        state_d   = (|(req_q & ACK_MASK)) ? S_WAIT : S_PAD;
      end
      S_WAIT: begin
        pend_d    = pend_q & ~bus.flush_ack;
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (pend_d == '0) begin
          state_d = S_PAD;
        end else if ((TIMEOUT_CYC != 0) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1))) begin
          timeout_d = 1'b1;
          pend_d    = '0;
          state_d   = S_PAD;
        end
      end
      S_PAD: begin
        if (pad_cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      pad_cnt_q  <= '0;
      time_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
      pad_cnt_q  <= pad_cnt_d;
      time_irq_q <= time_irq_i;
    end
  end

  // Request vector is only observed in ISSUE, so it needs no reset value.
  always_ff @(posedge clk_i) begin
    req_q <= req_d;
  end

  always_comb begin
    bus.flush = '0;
    if (state_q == S_ISSUE) begin
      bus.flush = req_q;
    end else if (state_q == S_WAIT) begin
      bus.flush = pend_q;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign halt_o          = (state_q != S_IDLE);
  assign set_pc_commit_o = (state_q == S_ISSUE);
  assign done_o          = (state_q == S_PAD) && (pad_cnt_q == '0);
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_flush_sequencer.sv
// Directed bench for flush_sequencer: per-request expectations queued at accept, checked at done_o.
module tb_flush_sequencer;

  localparam int NUM_CH = 16;
  localparam int PAD_W  = 32;
  localparam int TMO    = 8;

  typedef struct {
    logic [NUM_CH-1:0] req;
    logic              tmo;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             set_pc, halt, done, tmo_o;
  logic [PAD_W-1:0] pad;
  logic             irq;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  exp_t             sb[$];

  flush_sequencer_if #(.NUM_CH(NUM_CH)) bus ();

  flush_sequencer #(
    .NUM_CH(NUM_CH), .ACK_MASK(16'h0010), .PAD_W(PAD_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave), .set_pc_commit_o(set_pc),
    .halt_o(halt), .pad_i(pad), .time_irq_i(irq), .done_o(done), .timeout_o(tmo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [NUM_CH-1:0] r, input logic t);
    bus.req_valid = 1'b1;
    bus.req       = r;
    check("accept_ready", 64'(bus.req_ready), 64'd1);
    sb.push_back('{req: r, tmo: t});
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req       = '0;
  endtask

  // Called in the ISSUE cycle (index 0); ack_mask bit i raises every ack in cycle i.
  task automatic wait_done(input int budget, input logic [31:0] ack_mask,
                           output int lat, output int fcnt, output int wcnt);
    logic [NUM_CH-1:0] uni;
    exp_t              e;
    bit                seen;
    uni = '0; lat = 0; fcnt = 0; wcnt = 0; seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      bus.flush_ack = ack_mask[i % 32] ? '1 : '0;
      uni |= bus.flush;
      if (bus.flush != '0) fcnt++;
      if (bus.flush != '0 && !set_pc) wcnt++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
      @(negedge clk);
    end
    bus.flush_ack = '0;
    check("done_seen", 64'(seen), 64'd1);
    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("sb_flush_union", 64'(uni), 64'(e.req));
      check("sb_timeout", 64'(tmo_o), 64'(e.tmo));
    end
  endtask

  int lat, fc, wc, irq_cyc, done_cyc;

  initial begin
    rst_n = 1'b0; bus.req_valid = 1'b0; bus.req = '0; bus.flush_ack = '0;
    pad = '0; irq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_flush",   64'(bus.flush), 64'd0);
    check("rst_setpc",   64'(set_pc), 64'd0);
    check("rst_halt",    64'(halt), 64'd0);
    check("rst_done",    64'(done), 64'd0);
    check("rst_timeout", 64'(tmo_o), 64'd0);
    check("rst_ready",   64'(bus.req_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: pulse-only channels, no pad
    issue(16'h0081, 1'b0);
    check("t1_flush", 64'(bus.flush), 64'h0081);
    check("t1_setpc", 64'(set_pc), 64'd1);
    check("t1_halt",  64'(halt), 64'd1);
    check("t1_ready", 64'(bus.req_ready), 64'd0);
    wait_done(8, 32'h0, lat, fc, wc);
    check("t1_latency", 64'(lat), 64'd1);
    check("t1_flush_cycles", 64'(fc), 64'd1);
    check("t1_pad_flush", 64'(bus.flush), 64'd0);
    @(negedge clk);
    check("t1_halt_after", 64'(halt), 64'd0);
    check("t1_done_after", 64'(done), 64'd0);

    // 2: handshake channel, ack in ISSUE ignored, real ack in 4th WAIT cycle
    issue(16'h0010, 1'b0);
    wait_done(20, 32'h0000_0011, lat, fc, wc);
    check("t2_flush_cycles", 64'(fc), 64'd5);
    check("t2_latency", 64'(lat), 64'd5);
    @(negedge clk);
    check("t2_halt_after", 64'(halt), 64'd0);

    // 3: handshake channel never acked -> timeout
    issue(16'h0010, 1'b1);
    wait_done(30, 32'h0, lat, fc, wc);
    check("t3_wait_cycles", 64'(wc), 64'(TMO));
    check("t3_latency", 64'(lat), 64'(TMO + 1));
    @(negedge clk);
    check("t3_sticky", 64'(tmo_o), 64'd1);
    check("t3_halt_after", 64'(halt), 64'd0);

    // 4: irq rises 3 cycles before PAD; done follows the load edge by pad cycles
    pad = 32'd20;
    irq = 1'b1;
    irq_cyc = cyc;
    @(negedge clk);
    issue(16'h0081, 1'b0);
    check("t4_timeout_cleared", 64'(tmo_o), 64'd0);
    wait_done(40, 32'h0, lat, fc, wc);
    done_cyc = cyc;
    check("t4_pad_delay", 64'(done_cyc - (irq_cyc + 1)), 64'd20);
    irq = 1'b0;
    pad = '0;
    @(negedge clk);

    // 5: held request while busy, then zero request
    bus.req_valid = 1'b1;
    bus.req       = 16'h0010;
    check("t5_ready", 64'(bus.req_ready), 64'd1);
    sb.push_back('{req: 16'h0010, tmo: 1'b0});
    @(negedge clk);
    bus.req = 16'h0002;
    check("t5_busy_ready", 64'(bus.req_ready), 64'd0);
    wait_done(20, 32'h0000_0004, lat, fc, wc);
    check("t5_latency", 64'(lat), 64'd3);
    @(negedge clk);
    check("t5_idle_ready", 64'(bus.req_ready), 64'd1);
    sb.push_back('{req: 16'h0002, tmo: 1'b0});
    @(negedge clk);
    check("t5_second_flush", 64'(bus.flush), 64'h0002);
    bus.req = '0;
    wait_done(8, 32'h0, lat, fc, wc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_zero_halt",  64'(halt), 64'd0);
      check("t5_zero_ready", 64'(bus.req_ready), 64'd1);
    end
    bus.req_valid = 1'b0;

    // 6: asynchronous reset during WAIT_ACK
    issue(16'h0010, 1'b0);
    @(negedge clk);
    check("t6_in_wait", 64'(bus.flush), 64'h0010);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_flush", 64'(bus.flush), 64'd0);
    check("t6_rst_halt",  64'(halt), 64'd0);
    check("t6_rst_setpc", 64'(set_pc), 64'd0);
    check("t6_rst_ready", 64'(bus.req_ready), 64'd1);
    check("t6_rst_done",  64'(done), 64'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    bus.flush_ack = '1;
    @(negedge clk);
    bus.flush_ack = '0;
    check("t6_ack_flush", 64'(bus.flush), 64'd0);
    check("t6_ack_halt",  64'(halt), 64'd0);
    @(negedge clk);
    check("t6_ack_done",  64'(done), 64'd0);
    issue(16'h0001, 1'b0);
    wait_done(8, 32'h0, lat, fc, wc);
    check("t6_recover_latency", 64'(lat), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
